l1_write_buffer: RTL and testbench
==================================

Name: l1_write_buffer

Overview:
- Write buffer between the L1 data cache's lower-memory port and the backing L2/memory.
- Absorbs L1 writebacks into a small FIFO and acknowledges them in 1 cycle.
- Forwards buffered data to L1 fills whose address matches a buffered entry.
- Passes non-matching fills downstream ahead of pending writes and drains writes to memory in the background.

Parameters:
DEPTH, 4, number of buffer entries (power of 2, >=2)
ADDR_W, 32, address width; bits [1:0] ignored (word granularity)
DATA_W, 32, data width of one block/word

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
l1_req  in  1  L1 request, level, held until l1_ready seen
l1_we  in  1  1=writeback, 0=fill read; stable while l1_req
l1_addr  in  ADDR_W  request address; stable while l1_req
l1_wdata  in  DATA_W  writeback data; stable while l1_req
l1_rdata  out  DATA_W  fill data, valid when l1_ready and request was a read
l1_ready  out  1  one-cycle completion pulse
mem_req  out  1  downstream request, held until mem_ack
mem_we  out  1  downstream write
mem_addr  out  ADDR_W  downstream address
mem_wdata  out  DATA_W  downstream write data
mem_rdata  in  DATA_W  downstream read data, valid with mem_ack
mem_ack  in  1  one-cycle downstream completion pulse
wb_count  out  $clog2(DEPTH)+1  occupied entries
wb_full  out  1  wb_count==DEPTH
wb_empty  out  1  wb_count==0

Behaviour:
- Reset, asynchronous, all state cleared:
  - l1_ready=0, l1_rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - All entries invalid, head=tail=0, wb_count=0, wb_empty=1, wb_full=0, FSM=IDLE.
- Reset mid-transaction abandons it; no replay. The memory side must tolerate mem_req dropping without an ack.
- All outputs are registered.
- FSM states: IDLE, RD_MEM, DRAIN, RESP.
- IDLE, priority order:
  - (1) l1_req & l1_we & !full: enqueue at tail, go to RESP (l1_ready at N+1).
  - (2) l1_req & !l1_we & match: load youngest matching entry's data into l1_rdata, go to RESP (l1_ready at N+1).
  - (3) l1_req & !l1_we & no match: drive mem_req=1, mem_we=0, mem_addr=l1_addr, go to RD_MEM.
  - (4) l1_req & l1_we & full: go to DRAIN (write stalls).
  - (5) !l1_req & !empty: drive the head entry to memory with mem_we=1, go to DRAIN.
  - (6) otherwise stay in IDLE.
- Match rule: valid entry with addr[ADDR_W-1:2]==l1_addr[ADDR_W-1:2]; youngest wins.
- RD_MEM: on mem_ack, l1_rdata<=mem_rdata, mem_req<=0, go to RESP.
- DRAIN: on mem_ack, pop head (invalidate, head++ mod DEPTH, count--), mem_req<=0, return to IDLE. The pending request is re-evaluated there.
- RESP: l1_ready=1 for exactly this cycle; l1_req is not sampled in this cycle; return to IDLE.
- Downstream interface:
  - mem_req/mem_we/mem_addr/mem_wdata are stable from assertion through the ack cycle.
  - mem_req drops the cycle after ack.
  - Only one outstanding downstream transaction at a time.
- Ordering:
  - Drains are issued in FIFO order.
  - A read bypassing pending writes is safe because matches are forwarded.
- Pointers wrap modulo DEPTH; count never exceeds DEPTH or goes below 0.
- A drain in flight is never preempted; an arriving l1_req waits for its ack.
- l1_wdata of a read and mem_rdata outside ack are ignored.

Optional Feature:
WB_COALESCE_EN
- Defined: a writeback whose word address matches a valid entry overwrites that entry's data in place.
  - No new entry is allocated; count is unchanged.
  - It is accepted even when full.
  - If the match is the head entry and that entry is currently being drained, the write stalls until the drain's ack.
- Undefined: every writeback allocates a new entry; read forwarding returns the youngest match.

Decomposition:
- Package wb_pkg:
  - wb_state_t enum (IDLE, RD_MEM, DRAIN, RESP).
  - wb_entry_t packed struct {valid, word_addr[ADDR_W-3:0], data}.
  - Default DEPTH/ADDR_W/DATA_W localparams.
- One sub-module, wb_entry_array:
  - Holds entries plus head/tail/count.
  - Push, pop and in-place update ports.
  - Combinational youngest-match search returning hit, index and data.
- The FSM and port registers stay in l1_write_buffer.

Test Plan:
- Write 0x100 data 0xAAAA0001 into empty buffer, l1_req held 1 cycle in IDLE -> l1_ready at N+1, wb_count=1; with l1_req low, mem_req/mem_we=1, addr 0x100 next cycle; mem_ack after 3 cycles -> wb_count=0, wb_empty=1.
- Writes 0x200=0x11, then 0x200=0x22 with drains stalled (mem_ack held 0), then read 0x200 -> l1_rdata=0x22 at N+1, no mem_req read issued.
  - WB_COALESCE_EN defined: wb_count=1. Undefined: wb_count=2.
- Fill 4 distinct addresses (DEPTH=4) with mem_ack held 0 -> wb_full=1; a 5th write stalls with no l1_ready; release mem_ack once -> head popped, 5th accepted, l1_ready pulses, wb_count=4.
- Read 0x300 (no match) with 2 writes pending -> mem_req with mem_we=0, addr 0x300 issued before any drain; mem_ack with mem_rdata 0xDEADBEEF -> l1_rdata=0xDEADBEEF, l1_ready next cycle; drains follow in FIFO order.
- Assert reset mid-DRAIN with 3 entries -> mem_req=0, wb_count=0, wb_empty=1, l1_ready=0 immediately; post-reset read 0x100 -> goes downstream.
- Back-to-back requests: l1_req held high through the l1_ready cycle -> request not double-counted; wb_count increments by exactly 1.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and default sizes for the L1 write buffer.
// The WB_COALESCE_EN build option is handled in l1_write_buffer.
package wb_pkg;
  localparam int WB_DEPTH  = 4;
  localparam int WB_ADDR_W = 32;
  localparam int WB_DATA_W = 32;
  localparam int WB_WA_W   = WB_ADDR_W - 2;

  typedef enum logic [1:0] {
    IDLE,
    RD_MEM,
    DRAIN,
    RESP
  } wb_state_t;

  typedef struct packed {
    logic                 valid;
    logic [WB_WA_W-1:0]   word_addr;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_entry_array.sv
// Circular entry store with head/tail/count and a youngest-match search.
// Count, full and empty are registered so they can drive ports directly.
module wb_entry_array
  import wb_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic [WB_WA_W-1:0]   push_addr,
  input  logic [WB_DATA_W-1:0] push_data,
  input  logic                 pop,
  input  logic                 upd,
  input  logic [PW-1:0]        upd_idx,
  input  logic [WB_DATA_W-1:0] upd_data,
  input  logic [WB_WA_W-1:0]   find_addr,
  output logic                 hit,
  output logic [PW-1:0]        hit_idx,
  output logic [WB_DATA_W-1:0] hit_data,
  output logic [WB_WA_W-1:0]   head_addr,
  output logic [WB_DATA_W-1:0] head_data,
  output logic [CW-1:0]        count,
  output logic                 full,
  output logic                 empty
);

  wb_entry_t     ents [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic          push_ok;
  logic          pop_ok;
  logic [CW-1:0] cnt_d;

  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign cnt_d   = count + CW'(push_ok) - CW'(pop_ok);

  assign head_addr = ents[head].word_addr;
  assign head_data = ents[head].data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        ents[i] <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (push_ok) begin
        ents[tail].valid     <= 1'b1;
        ents[tail].word_addr <= push_addr;
        ents[tail].data      <= push_data;
        tail <= tail + PW'(1);
      end
      if (upd)
        ents[upd_idx].data <= upd_data;
      if (pop_ok) begin
        ents[head].valid <= 1'b0;
        head <= head + PW'(1);
      end
      count <= cnt_d;
      full  <= (cnt_d == CW'(DEPTH));
      empty <= (cnt_d == '0);
    end
  end

  // Walk oldest to youngest so the last hit found is the youngest.
  always_comb begin
    logic [PW-1:0] idx;
    idx      = '0;
    hit      = 1'b0;
    hit_idx  = '0;
    hit_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (ents[idx].valid &&
          ents[idx].word_addr == find_addr) begin
        hit      = 1'b1;
        hit_idx  = idx;
        hit_data = ents[idx].data;
      end
    end
  end

endmodule

// File: rtl/l1_write_buffer.sv
// L1 write buffer: absorbs writebacks, forwards matches, drains in background.
// Define WB_COALESCE_EN to merge writebacks into a matching entry in place.
module l1_write_buffer
  import wb_pkg::*;
#(
  parameter int DEPTH  = WB_DEPTH,
  parameter int ADDR_W = WB_ADDR_W,
  parameter int DATA_W = WB_DATA_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    l1_req,
  input  logic                    l1_we,
  input  logic [ADDR_W-1:0]       l1_addr,
  input  logic [DATA_W-1:0]       l1_wdata,
  output logic [DATA_W-1:0]       l1_rdata,
  output logic                    l1_ready,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [DATA_W-1:0]       mem_wdata,
  input  logic [DATA_W-1:0]       mem_rdata,
  input  logic                    mem_ack,
  output logic [$clog2(DEPTH):0]  wb_count,
  output logic                    wb_full,
  output logic                    wb_empty
);

  localparam int PW = $clog2(DEPTH);

  wb_state_t state_q;
  wb_state_t state_d;

  logic              push;
  logic              pop;
  logic              upd;
  logic              hit;
  logic [PW-1:0]     hit_idx;
  logic [DATA_W-1:0] hit_data;
  logic [ADDR_W-3:0] head_addr;
  logic [DATA_W-1:0] head_data;

  logic [DATA_W-1:0] rdata_d;
  logic              req_d;
  logic              we_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;

  logic wr;
  logic rd;
  logic wr_upd;
  logic wr_push;
  logic wr_stall;
  logic rd_hit;
  logic rd_miss;
  logic drain;

  wb_entry_array #(.DEPTH(DEPTH)) u_ents (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_addr (l1_addr[ADDR_W-1:2]),
    .push_data (l1_wdata),
    .pop       (pop),
    .upd       (upd),
    .upd_idx   (hit_idx),
    .upd_data  (l1_wdata),
    .find_addr (l1_addr[ADDR_W-1:2]),
    .hit       (hit),
    .hit_idx   (hit_idx),
    .hit_data  (hit_data),
    .head_addr (head_addr),
    .head_data (head_data),
    .count     (wb_count),
    .full      (wb_full),
    .empty     (wb_empty)
  );

  assign wr = l1_req & l1_we;
  assign rd = l1_req & ~l1_we;

`ifdef WB_COALESCE_EN
  assign wr_upd = wr & hit;
`else
  assign wr_upd = 1'b0;
`endif

  // Mutually exclusive IDLE decisions, in priority order.
  assign wr_push  = wr & ~wr_upd & ~wb_full;
  assign wr_stall = wr & ~wr_upd & wb_full;
  assign rd_hit   = rd & hit;
  assign rd_miss  = rd & ~hit;
  assign drain    = ~l1_req & ~wb_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          wr_upd, wr_push, rd_hit: state_d = RESP;
          rd_miss:                 state_d = RD_MEM;
          wr_stall, drain:         state_d = DRAIN;
          default:                 state_d = IDLE;
        endcase
      end
      RD_MEM: if (mem_ack) state_d = RESP;
      DRAIN:  if (mem_ack) state_d = IDLE;
      RESP:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rdata_d = l1_rdata;
    req_d   = mem_req;
    we_d    = mem_we;
    addr_d  = mem_addr;
    wdata_d = mem_wdata;
    push    = 1'b0;
    pop     = 1'b0;
    upd     = 1'b0;
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          wr_upd:  upd = 1'b1;
          wr_push: push = 1'b1;
          rd_hit:  rdata_d = hit_data;
          rd_miss: begin
            req_d  = 1'b1;
            we_d   = 1'b0;
            addr_d = l1_addr;
          end
          wr_stall, drain: begin
            req_d   = 1'b1;
            we_d    = 1'b1;
            addr_d  = {head_addr, 2'b00};
            wdata_d = head_data;
          end
          default: ;
        endcase
      end
      RD_MEM: begin
        if (mem_ack) begin
          rdata_d = mem_rdata;
          req_d   = 1'b0;
        end
      end
      DRAIN: begin
        if (mem_ack) begin
          pop   = 1'b1;
          req_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      l1_rdata  <= '0;
      l1_ready  <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      l1_rdata  <= rdata_d;
      l1_ready  <= (state_d == RESP);
      mem_req   <= req_d;
      mem_we    <= we_d;
      mem_addr  <= addr_d;
      mem_wdata <= wdata_d;
    end
  end

endmodule

// File: tb/tb_l1_write_buffer.sv
// Directed bench for l1_write_buffer (DEPTH=4, 32-bit address/data).
// Expected values track WB_COALESCE_EN when it is defined.
module tb_l1_write_buffer;
  logic        clk = 1'b0;
  logic        reset;
  logic        l1_req;
  logic        l1_we;
  logic [31:0] l1_addr;
  logic [31:0] l1_wdata;
  logic [31:0] l1_rdata;
  logic        l1_ready;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [2:0]  wb_count;
  logic        wb_full;
  logic        wb_empty;

  int tests = 0;
  int fails = 0;

  l1_write_buffer dut (
    .clk       (clk),
    .reset     (reset),
    .l1_req    (l1_req),
    .l1_we     (l1_we),
    .l1_addr   (l1_addr),
    .l1_wdata  (l1_wdata),
    .l1_rdata  (l1_rdata),
    .l1_ready  (l1_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .wb_count  (wb_count),
    .wb_full   (wb_full),
    .wb_empty  (wb_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request, wait for l1_ready, then step past the RESP cycle
  // leaving l1_req high so the caller can chain the next request.
  task automatic do_req(input logic we, input logic [31:0] a,
                        input logic [31:0] d);
    int n;
    n = 0;
    l1_req = 1'b1;
    l1_we = we;
    l1_addr = a;
    l1_wdata = d;
    do begin
      tick();
      n++;
    end while (!l1_ready && n < 20);
    chk("req_ready", {31'd0, l1_ready}, 32'd1);
    tick();
  endtask

  task automatic drain(input logic [31:0] a, input logic [31:0] d);
    int n;
    n = 0;
    while (!mem_req && n < 20) begin
      tick();
      n++;
    end
    chk("drain_req", {31'd0, mem_req}, 32'd1);
    chk("drain_we", {31'd0, mem_we}, 32'd1);
    chk("drain_addr", mem_addr, a);
    chk("drain_data", mem_wdata, d);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("drain_drop", {31'd0, mem_req}, 32'd0);
  endtask

  initial begin
    int  n;
    logic quiet;
    reset = 1'b1;
    l1_req = 1'b0;
    l1_we = 1'b0;
    l1_addr = '0;
    l1_wdata = '0;
    mem_rdata = '0;
    mem_ack = 1'b0;
    #1;
    chk("rst_ready", {31'd0, l1_ready}, 32'd0);
    chk("rst_rdata", l1_rdata, 32'd0);
    chk("rst_mreq", {31'd0, mem_req}, 32'd0);
    chk("rst_maddr", mem_addr, 32'd0);
    chk("rst_count", {29'd0, wb_count}, 32'd0);
    chk("rst_empty", {31'd0, wb_empty}, 32'd1);
    chk("rst_full", {31'd0, wb_full}, 32'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // single write then background drain
    do_req(1'b1, 32'h100, 32'hAAAA0001);
    l1_req = 1'b0;
    chk("t1_count", {29'd0, wb_count}, 32'd1);
    chk("t1_pulse", {31'd0, l1_ready}, 32'd0);
    tick();
    chk("t1_mreq", {31'd0, mem_req}, 32'd1);
    chk("t1_mwe", {31'd0, mem_we}, 32'd1);
    chk("t1_maddr", mem_addr, 32'h100);
    chk("t1_mdata", mem_wdata, 32'hAAAA0001);
    tick();
    tick();
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("t1_cnt0", {29'd0, wb_count}, 32'd0);
    chk("t1_empty", {31'd0, wb_empty}, 32'd1);
    chk("t1_drop", {31'd0, mem_req}, 32'd0);

    // forwarding of the youngest write
    do_req(1'b1, 32'h200, 32'h11);
    do_req(1'b1, 32'h200, 32'h22);
    l1_we = 1'b0;
    tick();
    chk("t2_ready", {31'd0, l1_ready}, 32'd1);
    chk("t2_rdata", l1_rdata, 32'h22);
    chk("t2_nomreq", {31'd0, mem_req}, 32'd0);
`ifdef WB_COALESCE_EN
    chk("t2_count", {29'd0, wb_count}, 32'd1);
`else
    chk("t2_count", {29'd0, wb_count}, 32'd2);
`endif
    tick();
    l1_req = 1'b0;
`ifndef WB_COALESCE_EN
    drain(32'h200, 32'h11);
`endif
    drain(32'h200, 32'h22);
    chk("t2_empty", {31'd0, wb_empty}, 32'd1);

    // fill to full, fifth write stalls behind one drain
    for (int i = 0; i < 4; i++)
      do_req(1'b1, 32'h400 + 32'(4 * i), 32'h40 + 32'(i));
    chk("t3_full", {31'd0, wb_full}, 32'd1);
    chk("t3_count", {29'd0, wb_count}, 32'd4);
    l1_addr = 32'h410;
    l1_wdata = 32'h44;
    quiet = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (l1_ready) quiet = 1'b0;
    end
    chk("t3_stall", {31'd0, quiet}, 32'd1);
    chk("t3_mreq", {31'd0, mem_req}, 32'd1);
    chk("t3_maddr", mem_addr, 32'h400);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("t3_pop", {29'd0, wb_count}, 32'd3);
    n = 0;
    while (!l1_ready && n < 10) begin
      tick();
      n++;
    end
    chk("t3_ready", {31'd0, l1_ready}, 32'd1);
    chk("t3_count4", {29'd0, wb_count}, 32'd4);
    tick();
    l1_req = 1'b0;
    for (int i = 1; i < 5; i++)
      drain(32'h400 + 32'(4 * i), 32'h40 + 32'(i));
    chk("t3_empty", {31'd0, wb_empty}, 32'd1);

    // read miss bypasses pending writes
    do_req(1'b1, 32'h500, 32'hA5);
    do_req(1'b1, 32'h504, 32'hA6);
    l1_we = 1'b0;
    l1_addr = 32'h300;
    tick();
    chk("t4_mreq", {31'd0, mem_req}, 32'd1);
    chk("t4_mwe", {31'd0, mem_we}, 32'd0);
    chk("t4_maddr", mem_addr, 32'h300);
    mem_rdata = 32'hDEADBEEF;
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    mem_rdata = '0;
    chk("t4_ready", {31'd0, l1_ready}, 32'd1);
    chk("t4_rdata", l1_rdata, 32'hDEADBEEF);
    tick();
    l1_req = 1'b0;
    drain(32'h500, 32'hA5);
    drain(32'h504, 32'hA6);

    // reset in the middle of a drain
    for (int i = 0; i < 3; i++)
      do_req(1'b1, 32'h700 + 32'(4 * i), 32'h70 + 32'(i));
    l1_req = 1'b0;
    tick();
    chk("t5_inflight", {31'd0, mem_req}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("t5_mreq", {31'd0, mem_req}, 32'd0);
    chk("t5_count", {29'd0, wb_count}, 32'd0);
    chk("t5_empty", {31'd0, wb_empty}, 32'd1);
    chk("t5_ready", {31'd0, l1_ready}, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    l1_req = 1'b1;
    l1_we = 1'b0;
    l1_addr = 32'h100;
    tick();
    chk("t5_rd_mreq", {31'd0, mem_req}, 32'd1);
    chk("t5_rd_mwe", {31'd0, mem_we}, 32'd0);
    chk("t5_rd_addr", mem_addr, 32'h100);
    mem_rdata = 32'h12345678;
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    mem_rdata = '0;
    chk("t5_rd_data", l1_rdata, 32'h12345678);
    tick();
    l1_req = 1'b0;

    // request held through the ready cycle counts once
    do_req(1'b1, 32'h600, 32'h66);
    l1_req = 1'b0;
    chk("t6_count", {29'd0, wb_count}, 32'd1);
    tick();
    tick();
    tick();
    chk("t6_hold", {29'd0, wb_count}, 32'd1);
    drain(32'h600, 32'h66);
    chk("t6_empty", {31'd0, wb_empty}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
